// File: rtl/hack_data_mem.sv
// Hack CPU data-memory responder: RAM, screen shadow with framebuffer write FIFO, and keyboard register.
// Decodes addressM into the RAM / SCREEN / KBD regions; reads are combinational, writes and key updates land on posedge clk.
module hack_data_mem #(
  parameter int RAM_WORDS  = 16384,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [12:0] fb_addr,
  output logic [15:0] fb_data,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  input  logic        kbd_release,
  output logic        fb_overflow,
  output logic        bad_access
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] shadow [8192];
  logic [28:0] fifoMem [FIFO_DEPTH];

  logic [FIFO_AW-1:0] wrPtr, rdPtr;
  logic [FIFO_AW:0]   count;
  logic [15:0]        kbdReg;
  logic [28:0]        head;

  logic isRam, isScreen, isKbd;
  logic screenWrite, fifoFull, pop, pushOk;

  assign isRam    = {1'b0, addressM} < RAM_LIMIT;
  assign isScreen = addressM[15:13] == 3'b010;
  assign isKbd    = addressM == 16'h6000;

  always_comb begin
    inM = 16'h0000;
    if (isRam)         inM = ram[addressM[RAM_AW-1:0]];
    else if (isScreen) inM = shadow[addressM[12:0]];
    else if (isKbd)    inM = kbdReg;
  end

  // Framebuffer handshake: the head entry transfers on any posedge where fb_valid && fb_ready;
  // fb_addr/fb_data hold the head and do not change until that transfer happens.
  assign fb_valid    = count != '0;
  assign head        = fifoMem[rdPtr];
  assign fb_addr     = head[28:16];
  assign fb_data     = head[15:0];
  assign screenWrite = writeM && isScreen;
  assign fifoFull    = count == FULL_COUNT;
  assign pop         = fb_valid && fb_ready;
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign pushOk      = screenWrite && (!fifoFull || pop);

  always_ff @(posedge clk) begin
    if (writeM && isRam) ram[addressM[RAM_AW-1:0]] <= outM;
    if (screenWrite)     shadow[addressM[12:0]] <= outM;
    if (pushOk)          fifoMem[wrPtr] <= {addressM[12:0], outM};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      kbdReg      <= 16'h0000;
      fb_overflow <= 1'b0;
      bad_access  <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (screenWrite && !pushOk) fb_overflow <= 1'b1;
      bad_access <= writeM && !isRam && !isScreen;
      if (kbd_valid)        kbdReg <= kbd_code;
      else if (kbd_release) kbdReg <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: memory map reads/writes, screen FIFO ordering/overflow, keyboard and reset.
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        fb_valid;
  logic        fb_ready;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_release;
  logic        fb_overflow;
  logic        bad_access;

  int vectors = 0;
  int miscompares = 0;
  logic [28:0] exp_q[$];

  hack_data_mem dut (
    .clk(clk), .reset_n(reset_n), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .kbd_valid(kbd_valid), .kbd_code(kbd_code), .kbd_release(kbd_release),
    .fb_overflow(fb_overflow), .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Framebuffer side: just before each posedge, a handshake retires the oldest expected entry.
  always begin
    @(negedge clk);
    #4;
    if (fb_valid === 1'b1 && fb_ready === 1'b1) begin
      if (exp_q.size() == 0) check("fb_unexpected_pop", {3'b0, fb_addr, fb_data}, 32'hFFFF_FFFF);
      else check("fb_entry", {3'b0, fb_addr, fb_data}, {3'b0, exp_q.pop_front()});
    end
  end

  // One write cycle; rdy is the fb_ready level during that cycle (left applied afterwards).
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic rdy);
    @(negedge clk);
    addressM = a; outM = d; writeM = 1'b1; fb_ready = rdy;
    if (a[15:13] == 3'b010 && (exp_q.size() < 8 || (rdy && exp_q.size() != 0)))
      exp_q.push_back({a[12:0], d});
    @(negedge clk);
    writeM = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk);
    addressM = a;
    #1 check(tag, {16'h0, inM}, {16'h0, exp});
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    fb_ready = 1'b1;
    for (int i = 0; i < 20 && fb_valid; i++) @(negedge clk);
    check({tag, "_empty"}, {31'h0, fb_valid}, 32'h0);
    check({tag, "_queue"}, exp_q.size(), 32'h0);
    fb_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; addressM = 16'h6000; outM = 16'h0; writeM = 1'b0; fb_ready = 1'b0;
    kbd_valid = 1'b0; kbd_code = 16'h0; kbd_release = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fb_valid", {31'h0, fb_valid}, 32'h0);
    check("rst_overflow", {31'h0, fb_overflow}, 32'h0);
    check("rst_bad_access", {31'h0, bad_access}, 32'h0);
    check("rst_kbd", {16'h0, inM}, 32'h0);
    reset_n = 1'b1;

    // RAM write/read, top-of-RAM preserved, read-during-write sees old data until the edge
    wr(16'h3FFF, 16'hABCD, 1'b0);
    wr(16'h0010, 16'h1234, 1'b0);
    rd("ram_0010", 16'h0010, 16'h1234);
    rd("ram_3fff", 16'h3FFF, 16'hABCD);
    @(negedge clk);
    addressM = 16'h0010; outM = 16'h5A5A; writeM = 1'b1;
    #1 check("ram_rdw_old", {16'h0, inM}, 32'h1234);
    @(negedge clk);
    writeM = 1'b0;
    #1 check("ram_rdw_new", {16'h0, inM}, 32'h5A5A);
    check("ram_no_bad", {31'h0, bad_access}, 32'h0);

    // Single screen write held while not ready, then accepted
    wr(16'h4005, 16'hFFFF, 1'b0);
    addressM = 16'h4005;
    #1 check("scr_valid", {31'h0, fb_valid}, 32'h1);
    check("scr_addr", {19'h0, fb_addr}, 32'h5);
    check("scr_data", {16'h0, fb_data}, 32'hFFFF);
    check("scr_shadow", {16'h0, inM}, 32'hFFFF);
    @(negedge clk);
    check("scr_hold_addr", {19'h0, fb_addr}, 32'h5);
    fb_ready = 1'b1;
    @(negedge clk);
    check("scr_popped", {31'h0, fb_valid}, 32'h0);
    fb_ready = 1'b0;

    // Fill to full, then push and pop together: accepted, no overflow
    for (int i = 0; i < 8; i++) wr(16'h4100 + 16'(i), 16'h0A00 + 16'(i), 1'b0);
    wr(16'h5FFF, 16'hBEEF, 1'b1);
    fb_ready = 1'b0;
    check("full_pushpop_ovf", {31'h0, fb_overflow}, 32'h0);
    check("full_pushpop_q", exp_q.size(), 32'h8);
    drain("drain_pushpop");

    // Nine writes to one address with no drain: ninth dropped, shadow keeps it
    for (int i = 1; i <= 9; i++) wr(16'h4020, 16'(i), 1'b0);
    check("ovf_set", {31'h0, fb_overflow}, 32'h1);
    check("ovf_q", exp_q.size(), 32'h8);
    rd("ovf_shadow", 16'h4020, 16'd9);
    drain("drain_ovf");
    check("ovf_sticky", {31'h0, fb_overflow}, 32'h1);

    // Keyboard register: load, release, both-at-once, rejected write
    @(negedge clk); kbd_valid = 1'b1; kbd_code = 16'd131;
    @(negedge clk); kbd_valid = 1'b0;
    rd("kbd_code", 16'h6000, 16'd131);
    @(negedge clk); kbd_release = 1'b1;
    @(negedge clk); kbd_release = 1'b0;
    rd("kbd_release", 16'h6000, 16'h0);
    @(negedge clk); kbd_valid = 1'b1; kbd_release = 1'b1; kbd_code = 16'd77;
    @(negedge clk); kbd_valid = 1'b0; kbd_release = 1'b0;
    rd("kbd_both", 16'h6000, 16'd77);
    wr(16'h6000, 16'h1111, 1'b0);
    check("kbd_wr_bad", {31'h0, bad_access}, 32'h1);
    rd("kbd_wr_keep", 16'h6000, 16'd77);
    check("bad_one_cycle", {31'h0, bad_access}, 32'h0);
    wr(16'h8000, 16'h2222, 1'b0);
    check("unmapped_bad", {31'h0, bad_access}, 32'h1);
    rd("unmapped_rd", 16'h8000, 16'h0);

    // Asynchronous reset with entries pending
    for (int i = 0; i < 3; i++) wr(16'h4200 + 16'(i), 16'h0C00 + 16'(i), 1'b0);
    @(negedge clk);
    addressM = 16'h6000;
    #2 reset_n = 1'b0;
    #1 check("arst_fb_valid", {31'h0, fb_valid}, 32'h0);
    check("arst_overflow", {31'h0, fb_overflow}, 32'h0);
    check("arst_kbd", {16'h0, inM}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    rd("arst_ram_kept", 16'h0010, 16'h5A5A);
    rd("arst_shadow_kept", 16'h4005, 16'hFFFF);
    rd("unmapped_7000", 16'h7000, 16'h0);
    @(negedge clk);
    check("arst_stays_empty", {31'h0, fb_valid}, 32'h0);

    repeat (2) @(negedge clk);
    check("final_queue", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
